// File: rtl/debounce_pkg.sv
// Shared types and constants for the input debounce stage.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE,
        LOW_TO_HIGH,
        HIGH_STABLE,
        HIGH_TO_LOW
    } db_state_t;

    localparam logic [7:0] GLITCH_MAX = 8'd255;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser bringing an asynchronous level into clk.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/input_debounce_fsm.sv
// Synchronise, debounce and edge-detect the raw A input level.
module input_debounce_fsm
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_in,
    input  logic       glitch_clr,
    output logic       a_clean,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy,
    output logic [7:0] glitch_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort;
    logic             rise_d, fall_d;
    logic             rise_q, fall_q;
    logic [7:0]       gcnt_q;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (raw_in),
        .q    (s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort   = 1'b0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            LOW_STABLE: begin
                if (s) begin
                    state_d = LOW_TO_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            LOW_TO_HIGH: begin
                if (!s) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH_STABLE: begin
                if (!s) begin
                    state_d = HIGH_TO_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            HIGH_TO_LOW: begin
                if (s) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LOW_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOW_STABLE;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Clear has priority over a same-cycle abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gcnt_q <= '0;
        end else if (glitch_clr) begin
            gcnt_q <= '0;
        end else if (abort && gcnt_q != GLITCH_MAX) begin
            gcnt_q <= gcnt_q + 8'd1;
        end
    end

    assign a_clean      = (state_q == HIGH_STABLE) || (state_q == HIGH_TO_LOW);
    assign busy         = (state_q == LOW_TO_HIGH) || (state_q == HIGH_TO_LOW);
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign glitch_count = gcnt_q;

endmodule

// File: tb/tb_input_debounce_fsm.sv
// Scoreboard bench: two configurations against a run-length reference model.
module tb_input_debounce_fsm;

    typedef struct {
        bit clean;
        int run;
        int gc;
        bit busy;
        bit rise;
        bit fall;
    } mst_t;

    typedef struct {
        mst_t a;
        mst_t b;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       raw_in = 1'b0;
    logic       glitch_clr = 1'b0;
    logic       a_clean_a, rise_a, fall_a, busy_a;
    logic [7:0] gc_a;
    logic       a_clean_b, rise_b, fall_b, busy_b;
    logic [7:0] gc_b;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    bit   hist[$];
    mst_t ma, mb;

    always #5 clk = ~clk;

    input_debounce_fsm u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .raw_in      (raw_in),
        .glitch_clr  (glitch_clr),
        .a_clean     (a_clean_a),
        .rise_pulse  (rise_a),
        .fall_pulse  (fall_a),
        .busy        (busy_a),
        .glitch_count(gc_a)
    );

    input_debounce_fsm #(
        .SYNC_STAGES    (3),
        .DEBOUNCE_CYCLES(2)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .raw_in      (raw_in),
        .glitch_clr  (glitch_clr),
        .a_clean     (a_clean_b),
        .rise_pulse  (rise_b),
        .fall_pulse  (fall_b),
        .busy        (busy_b),
        .glitch_count(gc_b)
    );

    // Clean level flips once s has disagreed with it for d samples in a row
    function automatic mst_t mstep(mst_t m, bit s, bit clr, int d);
        mst_t n;
        bit   ab;
        n = m;
        n.rise = 0;
        n.fall = 0;
        ab = 0;
        if (s != m.clean) begin
            n.run = m.run + 1;
            if (n.run == d) begin
                n.clean = s;
                n.run = 0;
                n.rise = s;
                n.fall = !s;
            end
        end else begin
            ab = (m.run > 0);
            n.run = 0;
        end
        n.busy = (n.run > 0);
        if (clr) n.gc = 0;
        else if (ab && m.gc < 255) n.gc = m.gc + 1;
        return n;
    endfunction

    function automatic mst_t mzero();
        mst_t z;
        z.clean = 0;
        z.run = 0;
        z.gc = 0;
        z.busy = 0;
        z.rise = 0;
        z.fall = 0;
        return z;
    endfunction

    task automatic model_reset();
        ma = mzero();
        mb = mzero();
        hist = {1'b0, 1'b0, 1'b0};
    endtask

    // Called at negedge+1: drive inputs, predict the next posedge, advance
    task automatic drive(bit r, bit c);
        exp_t e;
        raw_in = r;
        glitch_clr = c;
        ma = mstep(ma, hist[hist.size() - 2], c, 4);
        mb = mstep(mb, hist[hist.size() - 3], c, 2);
        hist.push_back(r);
        e.a = ma;
        e.b = mb;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic chk(string nm, mst_t e, logic ac, logic rp, logic fp,
                       logic bz, logic [7:0] gc);
        total++;
        if (ac !== e.clean || rp !== e.rise || fp !== e.fall ||
            bz !== e.busy || gc !== 8'(e.gc)) begin
            bad++;
            $display("FAIL %s t=%0t got clean=%b rise=%b fall=%b busy=%b gc=%0d want clean=%b rise=%b fall=%b busy=%b gc=%0d",
                     nm, $time, ac, rp, fp, bz, gc,
                     e.clean, e.rise, e.fall, e.busy, e.gc);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("cfg_2_4", e.a, a_clean_a, rise_a, fall_a, busy_a, gc_a);
            chk("cfg_3_2", e.b, a_clean_b, rise_b, fall_b, busy_b, gc_b);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        mst_t z;
        int   lvl;
        int   len;
        z = mzero();
        model_reset();
        #2;
        chk("reset_a", z, a_clean_a, rise_a, fall_a, busy_a, gc_a);
        chk("reset_b", z, a_clean_b, rise_b, fall_b, busy_b, gc_b);
        @(negedge clk);
        #1;
        reset = 1'b1;

        repeat (4) drive(0, 0);
        repeat (10) drive(1, 0);
        repeat (10) drive(0, 0);
        repeat (3) drive(1, 0);
        repeat (8) drive(0, 0);
        repeat (10) drive(1, 0);
        repeat (2) drive(0, 0);
        repeat (10) drive(1, 0);
        repeat (10) drive(0, 0);

        // Enter a qualification of the rise, then reset asynchronously
        repeat (4) drive(1, 0);
        total++;
        if (busy_a !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_busy got=%b want=1", busy_a);
        end
        reset = 1'b0;
        #1;
        chk("async_rst_a", z, a_clean_a, rise_a, fall_a, busy_a, gc_a);
        chk("async_rst_b", z, a_clean_b, rise_b, fall_b, busy_b, gc_b);
        repeat (2) @(negedge clk);
        #1;
        model_reset();
        reset = 1'b1;
        repeat (10) drive(1, 0);
        repeat (10) drive(0, 0);

        // Saturate the glitch counter, then clear on an abort cycle
        repeat (260) begin
            drive(1, 0);
            drive(0, 0);
            drive(0, 0);
        end
        total++;
        if (gc_a !== 8'd255) begin
            bad++;
            $display("FAIL saturate got=%0d want=255", gc_a);
        end
        drive(1, 0);
        drive(0, 0);
        drive(0, 0);
        drive(0, 1);
        drive(0, 0);
        repeat (4) drive(0, 0);

        repeat (300) begin
            lvl = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            repeat (len) drive(lvl[0], $urandom_range(0, 31) == 0);
        end
        repeat (8) drive(0, 0);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
